// File: rtl/ula_pkg.sv
// Shared definitions for the ULA operation sequencer: opcodes, default
// widths and the sequencer state encoding.
package ula_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_OPW   = 2;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_SHL  = 2'd2;
  localparam logic [1:0] OP_NAND = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ula_seq_if.sv
// Bundle of the sequencer's upstream instruction handshake, the ULA
// operand/result bus and the downstream result handshake.
// slave  : the sequencer side.
// master : the environment (instruction source, ULA, result consumer).
interface ula_seq_if import ula_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int OPW   = DEFAULT_OPW
);
  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_use_acc;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_r;
  logic             alu_status_d;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_r;
  logic             out_zero;
  logic             out_status;
  logic [WIDTH-1:0] acc;

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_use_acc, alu_r, alu_status_d, out_ready,
    output in_ready, alu_op, alu_a, alu_b, out_valid, out_r, out_zero, out_status, acc
  );

  modport master (
    output in_valid, in_op, in_a, in_b, in_use_acc, alu_r, alu_status_d, out_ready,
    input  in_ready, alu_op, alu_a, alu_b, out_valid, out_r, out_zero, out_status, acc
  );
endinterface

// File: rtl/ula_seq_capture.sv
// Result capture registers: ULA result, status bit, zero flag and the
// accumulator, all loaded together at the end of the execute cycle.
module ula_seq_capture import ula_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_status_d,
  output logic [WIDTH-1:0] out_r,
  output logic             out_zero,
  output logic             out_status,
  output logic [WIDTH-1:0] acc
);
  // The accumulator always equals the last captured result, so one
  // register serves both outputs.
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             status_q, status_d;

  // Next-state: load a fresh capture, otherwise hold.
  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    status_d = status_q;
    if (load) begin
      result_d = alu_r;
      zero_d   = (alu_r == '0);
      status_d = alu_status_d;
    end
  end

  // Capture registers; a cleared result is zero, so the zero flag resets high.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      status_q <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      status_q <= status_d;
    end
  end

  assign out_r      = result_q;
  assign acc        = result_q;
  assign out_zero   = zero_q;
  assign out_status = status_q;
endmodule

// File: rtl/ula_seq.sv
// Operation sequencer around the 8-bit ULA: registers one instruction at a
// time onto the ULA inputs, captures the result one cycle later and offers
// it downstream. Back-to-back issue from DONE gives one op per two cycles.
// Optional statistics counters are built when ULA_SEQ_STATS_EN is defined.
module ula_seq import ula_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int OPW   = DEFAULT_OPW
) (
  input  logic        clk,
  input  logic        rst,
  ula_seq_if.slave    bus
`ifdef ULA_SEQ_STATS_EN
  ,
  output logic [15:0] op_count,
  output logic [15:0] zero_count
`endif
);
  state_t           state_q, state_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             in_ready;
  logic             out_valid;
  logic             accept;
  logic             capture_load;
  logic [WIDTH-1:0] out_r;
  logic             out_zero;
  logic             out_status;
  logic [WIDTH-1:0] acc;

  // Next-state, handshake outputs and instruction latch.
  always_comb begin
    state_d      = state_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    capture_load = 1'b0;
    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_EXEC: begin
        capture_load = 1'b1;
        state_d      = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = bus.out_ready;
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    accept = in_ready && bus.in_valid;
    // acc is already the presented result when accepting from DONE
    if (accept) begin
      alu_op_d = bus.in_op;
      alu_a_d  = bus.in_use_acc ? acc : bus.in_a;
      alu_b_d  = bus.in_b;
      state_d  = ST_EXEC;
    end
  end

  // State and ULA operand registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      alu_op_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      alu_op_q <= alu_op_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
    end
  end

  ula_seq_capture #(.WIDTH(WIDTH)) u_capture (
    .clk          (clk),
    .rst          (rst),
    .load         (capture_load),
    .alu_r        (bus.alu_r),
    .alu_status_d (bus.alu_status_d),
    .out_r        (out_r),
    .out_zero     (out_zero),
    .out_status   (out_status),
    .acc          (acc)
  );

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.out_r      = out_r;
  assign bus.out_zero   = out_zero;
  assign bus.out_status = out_status;
  assign bus.acc        = acc;

`ifdef ULA_SEQ_STATS_EN
  logic        out_fire;
  logic [15:0] op_count_q, op_count_d;
  logic [15:0] zero_count_q, zero_count_d;

  // Saturating counts of output handshakes and of zero results among them.
  always_comb begin
    op_count_d   = op_count_q;
    zero_count_d = zero_count_q;
    out_fire     = out_valid && bus.out_ready;
    if (out_fire && (op_count_q != 16'hFFFF)) op_count_d = op_count_q + 16'd1;
    if (out_fire && out_zero && (zero_count_q != 16'hFFFF)) zero_count_d = zero_count_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_q   <= '0;
      zero_count_q <= '0;
    end else begin
      op_count_q   <= op_count_d;
      zero_count_q <= zero_count_d;
    end
  end

  assign op_count   = op_count_q;
  assign zero_count = zero_count_q;
`endif
endmodule
